cpu_csr_axi_master: RTL

Single-outstanding AXI4 master that issues single-beat CSR reads and writes to cpu_csr and slaves of the same shape. Core-side logic posts one command at a time on a valid/ready interface and gets back one response on a valid/ready interface. Sits between the CPU control path or debug bridge and the CSR block's AXI slave port.

---
 rtl/cpu_csr_pkg.sv | 24 ++
 rtl/cpu_csr_axi_timeout.sv | 30 +++
 rtl/cpu_csr_axi_master.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_csr_pkg.sv
// Shared constants and state encoding for the CSR AXI master.
// The optional transaction timeout is enabled by defining CPU_CSR_MASTER_TIMEOUT_EN.
package cpu_csr_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_DATA,
    ST_RSP
  } master_state_t;

endpackage

// File: rtl/cpu_csr_axi_timeout.sv
// Loadable down-counter; o_expired pulses on the last enabled cycle of the budget.
// Only instantiated when CPU_CSR_MASTER_TIMEOUT_EN is defined.
module cpu_csr_axi_timeout #(
  parameter int LOAD_VAL = 256
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  localparam int CNT_W = $clog2(LOAD_VAL + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CNT_W'(LOAD_VAL);
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Fires while the final budgeted cycle is in progress so the FSM leaves on that edge
  assign o_expired = i_en && (r_cnt == CNT_W'(1));

endmodule

// File: rtl/cpu_csr_axi_master.sv
// Single-outstanding AXI4 master issuing single-beat CSR reads/writes.
// Define CPU_CSR_MASTER_TIMEOUT_EN to abort stalled transactions after TIMEOUT_CYCLES.
module cpu_csr_axi_master
  import cpu_csr_pkg::*;
#(
  parameter int ADDR_W         = 5,
  parameter int ID_W           = 5,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              s_aclk,
  input  logic              s_aresetn,
  input  logic              cmd_valid,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_wstrb,
  output logic              cmd_ready,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              rsp_err,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [ID_W-1:0]   m_axi_awid,
  output logic [7:0]        m_axi_awlen,
  output logic [2:0]        m_axi_awsize,
  output logic [1:0]        m_axi_awburst,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [31:0]       m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wlast,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [ID_W-1:0]   m_axi_bid,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [ID_W-1:0]   m_axi_arid,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [31:0]       m_axi_rdata,
  input  logic [ID_W-1:0]   m_axi_rid,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  master_state_t     r_state;
  logic              r_cmd_ready;
  logic [ID_W-1:0]   r_id_cnt;
  logic [ID_W-1:0]   r_issued_id;
  logic [ADDR_W-1:0] r_awaddr;
  logic [ID_W-1:0]   r_awid;
  logic [2:0]        r_awsize;
  logic [1:0]        r_awburst;
  logic              r_awvalid;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wstrb;
  logic              r_wlast;
  logic              r_wvalid;
  logic              r_bready;
  logic [ADDR_W-1:0] r_araddr;
  logic [ID_W-1:0]   r_arid;
  logic [2:0]        r_arsize;
  logic [1:0]        r_arburst;
  logic              r_arvalid;
  logic              r_rready;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_rdata;
  logic [1:0]        r_rsp_resp;
  logic              r_rsp_err;

  logic              w_accept;
  logic              w_expired;
  logic              w_aw_done;
  logic              w_w_done;
  logic [ADDR_W-1:0] w_addr_aligned;
  logic              w_addr_lsb_unused;

  assign w_accept          = (r_state == ST_IDLE) && cmd_valid;
  assign w_addr_aligned    = {cmd_addr[ADDR_W-1:2], 2'b00};
  assign w_addr_lsb_unused = ^cmd_addr[1:0];
  // A channel counts as done if it already handshook or is handshaking now
  assign w_aw_done         = !r_awvalid || m_axi_awready;
  assign w_w_done          = !r_wvalid || m_axi_wready;

`ifdef CPU_CSR_MASTER_TIMEOUT_EN
  localparam logic IDLE_DRAIN = 1'b1;
  logic w_active;
  assign w_active = (r_state == ST_WR_REQ) || (r_state == ST_WR_RESP) ||
                    (r_state == ST_RD_REQ) || (r_state == ST_RD_DATA);

  cpu_csr_axi_timeout #(
    .LOAD_VAL (TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk     (s_aclk),
    .i_rst_n   (s_aresetn),
    .i_load    (w_accept),
    .i_en      (w_active),
    .o_expired (w_expired)
  );
`else
  localparam logic IDLE_DRAIN = 1'b0;
  logic w_timeout_unused;
  assign w_timeout_unused = (TIMEOUT_CYCLES == 0);
  assign w_expired        = 1'b0;
`endif

  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b1;
      r_id_cnt    <= '0;
      r_issued_id <= '0;
      r_awaddr    <= '0;
      r_awid      <= '0;
      r_awsize    <= '0;
      r_awburst   <= '0;
      r_awvalid   <= 1'b0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_wlast     <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_araddr    <= '0;
      r_arid      <= '0;
      r_arsize    <= '0;
      r_arburst   <= '0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_expired) begin
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_bready    <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b1;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= AXI_RESP_DECERR;
      r_rsp_err   <= 1'b1;
      r_state     <= ST_RSP;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_cmd_ready <= 1'b0;
            r_bready    <= 1'b0;
            r_rready    <= 1'b0;
            r_issued_id <= r_id_cnt;
            r_id_cnt    <= r_id_cnt + 1'b1;
            if (cmd_write) begin
              r_awaddr  <= w_addr_aligned;
              r_awid    <= r_id_cnt;
              r_awsize  <= AXI_SIZE_4B;
              r_awburst <= AXI_BURST_INCR;
              r_wdata   <= cmd_wdata;
              r_wstrb   <= cmd_wstrb;
              r_wlast   <= 1'b1;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= ST_WR_REQ;
            end else begin
              r_araddr  <= w_addr_aligned;
              r_arid    <= r_id_cnt;
              r_arsize  <= AXI_SIZE_4B;
              r_arburst <= AXI_BURST_INCR;
              r_arvalid <= 1'b1;
              r_state   <= ST_RD_REQ;
            end
          end
        end
        ST_WR_REQ: begin
          if (r_awvalid && m_axi_awready) r_awvalid <= 1'b0;
          if (r_wvalid && m_axi_wready)   r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (m_axi_bvalid) begin
            r_bready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= m_axi_bresp;
            r_rsp_err   <= (m_axi_bresp != AXI_RESP_OKAY) || (m_axi_bid != r_issued_id);
            r_state     <= ST_RSP;
          end
        end
        ST_RD_REQ: begin
          if (m_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (m_axi_rvalid) begin
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= m_axi_rdata;
            r_rsp_resp  <= m_axi_rresp;
            r_rsp_err   <= (m_axi_rresp != AXI_RESP_OKAY) || (m_axi_rid != r_issued_id) ||
                           !m_axi_rlast;
            r_state     <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_bready    <= IDLE_DRAIN;
            r_rready    <= IDLE_DRAIN;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_resp      = r_rsp_resp;
  assign rsp_err       = r_rsp_err;
  assign m_axi_awaddr  = r_awaddr;
  assign m_axi_awid    = r_awid;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = r_awsize;
  assign m_axi_awburst = r_awburst;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = r_wstrb;
  assign m_axi_wlast   = r_wlast;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_bready;
  assign m_axi_araddr  = r_araddr;
  assign m_axi_arid    = r_arid;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = r_arsize;
  assign m_axi_arburst = r_arburst;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;

endmodule
